// File: rtl/calc_core_param.sv
// Parametrised register-file calculator: IDLE->READ->EXEC->WB->FIN, one instruction per Go.
// Go sampled at edge k, result/flags written at edge k+3, DONE pulses for one cycle after that.
module calc_core_param #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Go,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] in1,
    input  logic [AW-1:0]    ra,
    input  logic [AW-1:0]    rb,
    input  logic [AW-1:0]    wd,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             zero,
    output logic             err,
    output logic             BUSY,
    output logic             DONE,
    output logic [2:0]       cso
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_WB   = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] in1_q;
    logic [AW-1:0]    ra_q, rb_q, wd_q;
    logic [WIDTH-1:0] opa_q, opb_q;
    logic [WIDTH-1:0] res_q, res_d;
    logic             c_q, c_d;
    logic             e_q, e_d;
    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] out_q;
    logic             carry_q, zero_q, err_q;
    logic [WIDTH:0]   sum_w, diff_w;

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  state_d = Go ? S_READ : S_IDLE;
            S_READ:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Top bit of the widened difference is the unsigned borrow.
    assign sum_w  = {1'b0, opa_q} + {1'b0, opb_q};
    assign diff_w = {1'b0, opa_q} - {1'b0, opb_q};

    always_comb begin
        res_d = '0;
        c_d   = 1'b0;
        e_d   = 1'b0;
        case (op_q)
            3'b000: res_d = opa_q ^ opb_q;
            3'b001: res_d = opa_q & opb_q;
            3'b010: begin
                res_d = diff_w[WIDTH-1:0];
                c_d   = diff_w[WIDTH];
            end
            3'b011: begin
                res_d = sum_w[WIDTH-1:0];
                c_d   = sum_w[WIDTH];
            end
            3'b100: res_d = opa_q | opb_q;
            3'b101: res_d = in1_q;
            3'b110: res_d = opa_q;
            default: e_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            in1_q   <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            wd_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            c_q     <= 1'b0;
            e_q     <= 1'b0;
            out_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && Go) begin
                op_q  <= Op;
                in1_q <= in1;
                ra_q  <= ra;
                rb_q  <= rb;
                wd_q  <= wd;
            end
            if (state_q == S_READ) begin
                opa_q <= regs_q[ra_q];
                opb_q <= regs_q[rb_q];
            end
            if (state_q == S_EXEC) begin
                res_q <= res_d;
                c_q   <= c_d;
                e_q   <= e_d;
            end
            // A reserved op only raises err; architectural state is left untouched.
            if (state_q == S_WB) begin
                if (e_q) begin
                    err_q <= 1'b1;
                end else begin
                    regs_q[wd_q] <= res_q;
                    out_q        <= res_q;
                    carry_q      <= c_q;
                    zero_q       <= (res_q == '0);
                    err_q        <= 1'b0;
                end
            end
        end
    end

    assign out   = out_q;
    assign carry = carry_q;
    assign zero  = zero_q;
    assign err   = err_q;
    assign BUSY  = (state_q != S_IDLE);
    assign DONE  = (state_q == S_FIN);
    assign cso   = state_q;

endmodule

// File: tb/tb_calc_core_param.sv
// Directed bench for calc_core_param: a 3-bit/4-entry and an 8-bit/8-entry instance.
module tb_calc_core_param;

    typedef struct packed {
        logic [7:0] out;
        logic       c;
        logic       z;
        logic       e;
    } exp_t;

    logic       CLK;
    logic       rst3, rst8;
    logic       go3, go8;
    logic [2:0] op;
    logic [7:0] in1;
    logic [2:0] ra, rb, wd;

    logic [2:0] out3;
    logic       carry3, zero3, err3, busy3, done3;
    logic [2:0] cso3;
    logic [7:0] out8;
    logic       carry8, zero8, err8, busy8, done8;
    logic [2:0] cso8;

    int   n_checks;
    int   n_fail;
    exp_t sb[$];

    calc_core_param #(.WIDTH(3), .DEPTH(4)) u3 (
        .CLK(CLK), .RST(rst3), .Go(go3), .Op(op), .in1(in1[2:0]),
        .ra(ra[1:0]), .rb(rb[1:0]), .wd(wd[1:0]),
        .out(out3), .carry(carry3), .zero(zero3), .err(err3),
        .BUSY(busy3), .DONE(done3), .cso(cso3)
    );

    calc_core_param #(.WIDTH(8), .DEPTH(8)) u8 (
        .CLK(CLK), .RST(rst8), .Go(go8), .Op(op), .in1(in1),
        .ra(ra), .rb(rb), .wd(wd),
        .out(out8), .carry(carry8), .zero(zero8), .err(err8),
        .BUSY(busy8), .DONE(done8), .cso(cso8)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Drive one instruction on the selected instance, then score its completion.
    task automatic issue(input bit sel, input string tag, input logic [2:0] op_v,
                         input logic [7:0] in1_v, input logic [2:0] ra_v,
                         input logic [2:0] rb_v, input logic [2:0] wd_v,
                         input logic [7:0] e_out, input logic e_c,
                         input logic e_z, input logic e_e);
        exp_t exp_r;
        int   cyc;
        @(negedge CLK);
        op  = op_v;
        in1 = in1_v;
        ra  = ra_v;
        rb  = rb_v;
        wd  = wd_v;
        if (sel) go8 = 1'b1; else go3 = 1'b1;
        sb.push_back('{out: e_out, c: e_c, z: e_z, e: e_e});
        @(posedge CLK);
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
            if (cyc == 1) begin
                go3 = 1'b0;
                go8 = 1'b0;
                op  = 3'b111;
                in1 = 8'hAA;
                ra  = 3'd0;
                rb  = 3'd0;
                wd  = 3'd0;
            end
        end while (!(sel ? done8 : done3) && cyc < 20);
        chk({tag, "_latency"}, 32'(cyc), 32'd4);
        exp_r = sb.pop_front();
        chk({tag, "_out"},   sel ? 32'(out8) : 32'(out3), 32'(exp_r.out));
        chk({tag, "_carry"}, sel ? 32'(carry8) : 32'(carry3), 32'(exp_r.c));
        chk({tag, "_zero"},  sel ? 32'(zero8) : 32'(zero3), 32'(exp_r.z));
        chk({tag, "_err"},   sel ? 32'(err8) : 32'(err3), 32'(exp_r.e));
        chk({tag, "_busy"},  sel ? 32'(busy8) : 32'(busy3), 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst3 = 1'b0;
        rst8 = 1'b0;
        go3  = 1'b0;
        go8  = 1'b0;
        op   = '0;
        in1  = '0;
        ra   = '0;
        rb   = '0;
        wd   = '0;
        repeat (2) @(negedge CLK);
        chk("rst_out3",  32'(out3), 32'd0);
        chk("rst_busy3", 32'(busy3), 32'd0);
        chk("rst_done3", 32'(done3), 32'd0);
        chk("rst_flags8", 32'({carry8, zero8, err8}), 32'd0);
        chk("rst_cso8",  32'(cso8), 32'd0);
        rst3 = 1'b1;
        rst8 = 1'b1;

        // 3-bit instance
        issue(1'b0, "load_r0", 3'b101, 8'h06, 3'd0, 3'd0, 3'd0, 8'h06, 1'b0, 1'b0, 1'b0);
        issue(1'b0, "load_r1", 3'b101, 8'h02, 3'd0, 3'd0, 3'd1, 8'h02, 1'b0, 1'b0, 1'b0);
        issue(1'b0, "add3",    3'b011, 8'h00, 3'd0, 3'd1, 3'd2, 8'h00, 1'b1, 1'b1, 1'b0);
        issue(1'b0, "resv",    3'b111, 8'h05, 3'd0, 3'd1, 3'd3, 8'h00, 1'b1, 1'b1, 1'b1);
        issue(1'b0, "sub3",    3'b010, 8'h00, 3'd0, 3'd1, 3'd2, 8'h04, 1'b0, 1'b0, 1'b0);
        issue(1'b0, "and3",    3'b001, 8'h00, 3'd0, 3'd1, 3'd2, 8'h02, 1'b0, 1'b0, 1'b0);
        issue(1'b0, "xor3",    3'b000, 8'h00, 3'd0, 3'd1, 3'd2, 8'h04, 1'b0, 1'b0, 1'b0);
        issue(1'b0, "or3",     3'b100, 8'h00, 3'd0, 3'd1, 3'd2, 8'h06, 1'b0, 1'b0, 1'b0);
        issue(1'b0, "resv_r3", 3'b110, 8'h00, 3'd3, 3'd0, 3'd3, 8'h00, 1'b0, 1'b1, 1'b0);

        // Reset asserted while LOAD R2=7 is in EXEC
        issue(1'b0, "pre_rst", 3'b101, 8'h05, 3'd0, 3'd0, 3'd1, 8'h05, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        op  = 3'b101;
        in1 = 8'h07;
        wd  = 3'd2;
        go3 = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        go3 = 1'b0;
        @(negedge CLK);
        chk("rst_mid_exec", 32'(cso3), 32'd2);
        rst3 = 1'b0;
        #1;
        chk("rst_mid_cso",   32'(cso3), 32'd0);
        chk("rst_mid_out",   32'(out3), 32'd0);
        chk("rst_mid_flags", 32'({carry3, zero3, err3, busy3, done3}), 32'd0);
        @(negedge CLK);
        rst3 = 1'b1;
        issue(1'b0, "pass_r2", 3'b110, 8'h00, 3'd2, 3'd0, 3'd3, 8'h00, 1'b0, 1'b1, 1'b0);

        // 8-bit instance
        issue(1'b1, "load_r7", 3'b101, 8'h05, 3'd0, 3'd0, 3'd7, 8'h05, 1'b0, 1'b0, 1'b0);
        issue(1'b1, "load_r3", 3'b101, 8'h09, 3'd0, 3'd0, 3'd3, 8'h09, 1'b0, 1'b0, 1'b0);
        issue(1'b1, "sub8",    3'b010, 8'h00, 3'd7, 3'd3, 3'd5, 8'hFC, 1'b1, 1'b0, 1'b0);
        issue(1'b1, "pass56",  3'b110, 8'h00, 3'd5, 3'd0, 3'd6, 8'hFC, 1'b0, 1'b0, 1'b0);
        issue(1'b1, "read_r6", 3'b110, 8'h00, 3'd6, 3'd0, 3'd0, 8'hFC, 1'b0, 1'b0, 1'b0);
        issue(1'b1, "add77",   3'b011, 8'h00, 3'd7, 3'd7, 3'd7, 8'h0A, 1'b0, 1'b0, 1'b0);
        issue(1'b1, "add_ovf", 3'b011, 8'h00, 3'd5, 3'd6, 3'd1, 8'hF8, 1'b1, 1'b0, 1'b0);

        // Go held high across three LOADs
        @(negedge CLK);
        op  = 3'b101;
        in1 = 8'h33;
        wd  = 3'd1;
        go8 = 1'b1;
        @(posedge CLK);
        for (int c = 1; c <= 14; c++) begin
            @(negedge CLK);
            chk($sformatf("held_done_c%0d", c), 32'(done8), 32'((c % 5) == 4));
            chk($sformatf("held_busy_c%0d", c), 32'(busy8), 32'((c % 5) != 0));
            if (c == 14) begin
                chk("held_out", 32'(out8), 32'h33);
                go8 = 1'b0;
            end
        end
        @(negedge CLK);
        chk("held_stop_busy", 32'(busy8), 32'd0);

        // Go and operands toggling while busy
        @(negedge CLK);
        op  = 3'b101;
        in1 = 8'h44;
        wd  = 3'd4;
        go8 = 1'b1;
        @(posedge CLK);
        for (int c = 1; c <= 4; c++) begin
            @(negedge CLK);
            go8 = (c == 2);
            op  = 3'b011;
            in1 = 8'(c);
            wd  = 3'd0;
            if (c == 4) begin
                chk("tog_done", 32'(done8), 32'd1);
                chk("tog_out",  32'(out8), 32'h44);
            end
        end
        @(negedge CLK);
        chk("tog_idle1", 32'(busy8), 32'd0);
        @(negedge CLK);
        chk("tog_idle2", 32'(busy8), 32'd0);
        issue(1'b1, "read_r4", 3'b110, 8'h00, 3'd4, 3'd0, 3'd2, 8'h44, 1'b0, 1'b0, 1'b0);
        issue(1'b1, "read_r0", 3'b110, 8'h00, 3'd0, 3'd0, 3'd2, 8'hFC, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
